reorder_buffer: RTL and testbench

- Circular in-order retirement buffer directly downstream of the reservation station and load/store buffer result buses.
- Allocates one ROB id per dispatched instruction and captures results from the RS and LSB buses.
- Supplies operand values to dispatch while entries wait in the buffer.
- Retires instructions in program order to the register file and store unit, and raises a pipeline flush on branch mispredict.

---
 rtl/reorder_buffer_if.sv | 53 +++++
 rtl/reorder_buffer.sv | 177 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch, result-bus, operand-query and retire signals of the reorder buffer.
// The ROB itself uses the slave view; dispatch/issue/retire logic uses the master view.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH_BIT = 3
);
  logic                     alloc_valid;
  logic [1:0]               alloc_kind;
  logic [4:0]               alloc_rd;
  logic                     alloc_pred_taken;
  logic [31:0]              alloc_alt_pc;
  logic [ROB_WIDTH_BIT-1:0] alloc_id;
  logic                     full;

  logic                     rs_ready;
  logic [ROB_WIDTH_BIT-1:0] rs_rob_id;
  logic [31:0]              rs_value;
  logic                     lsb_ready;
  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id;
  logic [31:0]              lsb_value;

  logic [ROB_WIDTH_BIT-1:0] query_id1;
  logic [ROB_WIDTH_BIT-1:0] query_id2;
  logic                     query_ready1;
  logic                     query_ready2;
  logic [31:0]              query_value1;
  logic [31:0]              query_value2;

  logic                     commit_valid;
  logic [1:0]               commit_kind;
  logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
  logic [4:0]               commit_rd;
  logic [31:0]              commit_value;
  logic                     flush;
  logic [31:0]              flush_pc;

  modport slave (
    input  alloc_valid, alloc_kind, alloc_rd, alloc_pred_taken, alloc_alt_pc,
    input  rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
    input  query_id1, query_id2,
    output alloc_id, full, query_ready1, query_ready2, query_value1, query_value2,
    output commit_valid, commit_kind, commit_rob_id, commit_rd, commit_value,
    output flush, flush_pc
  );

  modport master (
    output alloc_valid, alloc_kind, alloc_rd, alloc_pred_taken, alloc_alt_pc,
    output rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
    output query_id1, query_id2,
    input  alloc_id, full, query_ready1, query_ready2, query_value1, query_value2,
    input  commit_valid, commit_kind, commit_rob_id, commit_rd, commit_value,
    input  flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: hands out ROB ids at dispatch, captures RS/LSB
// results, forwards operands to dispatch and retires one entry per cycle, flushing on mispredict.
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = 3
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  reorder_buffer_if.slave rob
);

  localparam int DEPTH = 1 << ROB_WIDTH_BIT;
  localparam logic [1:0] KIND_BRANCH = 2'd2;

  typedef logic [ROB_WIDTH_BIT-1:0] id_t;
  typedef logic [ROB_WIDTH_BIT:0]   cnt_t;

  localparam id_t  ID_ONE   = {{(ROB_WIDTH_BIT-1){1'b0}}, 1'b1};
  localparam id_t  ID_ZERO  = {ROB_WIDTH_BIT{1'b0}};
  localparam cnt_t CNT_ONE  = {{ROB_WIDTH_BIT{1'b0}}, 1'b1};
  localparam cnt_t CNT_ZERO = {(ROB_WIDTH_BIT+1){1'b0}};

  logic [1:0]       kind_r   [DEPTH];
  logic [4:0]       rd_r     [DEPTH];
  logic [31:0]      alt_pc_r [DEPTH];
  logic [31:0]      value_r  [DEPTH];
  logic [DEPTH-1:0] pred_r;
  logic [DEPTH-1:0] ready_r;
  id_t              head_r;
  id_t              tail_r;
  cnt_t             count_r;

  logic             commit_valid_r;
  logic [1:0]       commit_kind_r;
  id_t              commit_rob_id_r;
  logic [4:0]       commit_rd_r;
  logic [31:0]      commit_value_r;
  logic             flush_r;
  logic [31:0]      flush_pc_r;

  logic             full_s;
  logic             alloc_acc_s;
  logic             commit_fire_s;
  logic             mispredict_s;
  logic             rs_wb_s;
  logic             lsb_wb_s;
  cnt_t             count_next_s;
  logic [32:0]      query1_s;
  logic [32:0]      query2_s;

  // An id is live when its distance from head is below the occupancy count.
  function automatic logic in_window(id_t id, id_t head, cnt_t cnt);
    id_t off;
    off = id - head;
    return ({1'b0, off} < cnt);
  endfunction

  function automatic logic [32:0] lookup(logic stored_rdy, logic [31:0] stored_val,
                                         logic lsb_hit, logic [31:0] lsb_val,
                                         logic rs_hit, logic [31:0] rs_val);
    logic [32:0] res;
    if (stored_rdy) begin
      res = {1'b1, stored_val};
    end else if (lsb_hit) begin
      res = {1'b1, lsb_val};
    end else if (rs_hit) begin
      res = {1'b1, rs_val};
    end else begin
      res = {1'b0, 32'h0000_0000};
    end
    return res;
  endfunction

  // Per-cycle accept/retire decisions, all gated by rdy_in.
  always_comb begin
    full_s        = count_r[ROB_WIDTH_BIT];  // count never exceeds DEPTH, so MSB means full
    alloc_acc_s   = rdy_in & rob.alloc_valid & ~full_s;
    commit_fire_s = rdy_in & (count_r != CNT_ZERO) & ready_r[head_r];
    mispredict_s  = commit_fire_s & (kind_r[head_r] == KIND_BRANCH)
                    & (value_r[head_r][0] != pred_r[head_r]);
    rs_wb_s       = rdy_in & rob.rs_ready & in_window(rob.rs_rob_id, head_r, count_r);
    lsb_wb_s      = rdy_in & rob.lsb_ready & in_window(rob.lsb_rob_id, head_r, count_r);
    count_next_s  = count_r + (alloc_acc_s ? CNT_ONE : CNT_ZERO)
                            - (commit_fire_s ? CNT_ONE : CNT_ZERO);
  end

  // Operand lookup for dispatch with same-cycle result bypass.
  always_comb begin
    query1_s = lookup(ready_r[rob.query_id1], value_r[rob.query_id1],
                      rob.lsb_ready && (rob.lsb_rob_id == rob.query_id1), rob.lsb_value,
                      rob.rs_ready && (rob.rs_rob_id == rob.query_id1), rob.rs_value);
    query2_s = lookup(ready_r[rob.query_id2], value_r[rob.query_id2],
                      rob.lsb_ready && (rob.lsb_rob_id == rob.query_id2), rob.lsb_value,
                      rob.rs_ready && (rob.rs_rob_id == rob.query_id2), rob.rs_value);
  end

  assign rob.query_ready1  = query1_s[32];
  assign rob.query_value1  = query1_s[31:0];
  assign rob.query_ready2  = query2_s[32];
  assign rob.query_value2  = query2_s[31:0];
  assign rob.alloc_id      = tail_r;
  assign rob.full          = full_s;
  assign rob.commit_valid  = commit_valid_r & rdy_in;
  assign rob.flush         = flush_r & rdy_in;
  assign rob.commit_kind   = commit_kind_r;
  assign rob.commit_rob_id = commit_rob_id_r;
  assign rob.commit_rd     = commit_rd_r;
  assign rob.commit_value  = commit_value_r;
  assign rob.flush_pc      = flush_pc_r;

  // Entry storage, ring pointers and registered retire outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        kind_r[i]   <= 2'b00;
        rd_r[i]     <= 5'd0;
        alt_pc_r[i] <= 32'h0000_0000;
        value_r[i]  <= 32'h0000_0000;
      end
      pred_r          <= {DEPTH{1'b0}};
      ready_r         <= {DEPTH{1'b0}};
      head_r          <= ID_ZERO;
      tail_r          <= ID_ZERO;
      count_r         <= CNT_ZERO;
      commit_valid_r  <= 1'b0;
      commit_kind_r   <= 2'b00;
      commit_rob_id_r <= ID_ZERO;
      commit_rd_r     <= 5'd0;
      commit_value_r  <= 32'h0000_0000;
      flush_r         <= 1'b0;
      flush_pc_r      <= 32'h0000_0000;
    end else if (rdy_in) begin
      commit_valid_r <= commit_fire_s;
      flush_r        <= mispredict_s;
      if (commit_fire_s) begin
        commit_kind_r   <= kind_r[head_r];
        commit_rob_id_r <= head_r;
        commit_rd_r     <= rd_r[head_r];
        commit_value_r  <= value_r[head_r];
      end
      if (mispredict_s) begin
        // Everything younger than the branch is on the wrong path, including this cycle's traffic.
        flush_pc_r <= alt_pc_r[head_r];
        ready_r    <= {DEPTH{1'b0}};
        head_r     <= ID_ZERO;
        tail_r     <= ID_ZERO;
        count_r    <= CNT_ZERO;
      end else begin
        if (alloc_acc_s) begin
          kind_r[tail_r]   <= rob.alloc_kind;
          rd_r[tail_r]     <= rob.alloc_rd;
          pred_r[tail_r]   <= rob.alloc_pred_taken;
          alt_pc_r[tail_r] <= rob.alloc_alt_pc;
          ready_r[tail_r]  <= 1'b0;
          tail_r           <= tail_r + ID_ONE;
        end
        if (rs_wb_s) begin
          ready_r[rob.rs_rob_id] <= 1'b1;
          value_r[rob.rs_rob_id] <= rob.rs_value;
        end
        // Written after the RS capture so the LSB value wins on an id collision.
        if (lsb_wb_s) begin
          ready_r[rob.lsb_rob_id] <= 1'b1;
          value_r[rob.lsb_rob_id] <= rob.lsb_value;
        end
        if (commit_fire_s) begin
          head_r <= head_r + ID_ONE;
        end
        count_r <= count_next_s;
      end
    end else begin
      commit_valid_r <= 1'b0;
      flush_r        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomised bench for reorder_buffer: a queue-based model of the buffer
// is checked every cycle, and literal expectations pin the test-plan scenarios.
module tb_reorder_buffer;
  localparam int W = 3;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b0;

  reorder_buffer_if #(.ROB_WIDTH_BIT(W)) rob();

  reorder_buffer #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .rob   (rob)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: program-order queue of live entries
  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt;
    logic        rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int          m_head = 0;
  logic        e_cv = 1'b0, e_flush = 1'b0;
  logic [1:0]  e_kind = 2'b00;
  logic [2:0]  e_id = 3'd0;
  logic [4:0]  e_rd = 5'd0;
  logic [31:0] e_val = 32'h0, e_fpc = 32'h0;

  function automatic int slot(input logic [2:0] id);
    return (int'(id) - m_head + 8) % 8;
  endfunction

  initial begin
    forever begin
      @(posedge clk_in or negedge rst_in);
      if (!rst_in) begin
        mq.delete(); m_head = 0;
        e_cv = 1'b0; e_flush = 1'b0; e_kind = 2'b00; e_id = 3'd0;
        e_rd = 5'd0; e_val = 32'h0; e_fpc = 32'h0;
      end else if (!rdy_in) begin
        e_cv = 1'b0; e_flush = 1'b0;
      end else begin : step
        bit was_full, do_commit, mis;
        int off;
        ent_t ne;
        was_full  = (mq.size() == 8);
        do_commit = (mq.size() > 0) && mq[0].rdy;
        mis = 1'b0;
        e_cv = do_commit;
        if (do_commit) begin
          e_kind = mq[0].kind; e_id = m_head[2:0]; e_rd = mq[0].rd; e_val = mq[0].val;
          mis = (mq[0].kind == 2'd2) && (mq[0].val[0] != mq[0].pred);
        end
        e_flush = mis;
        if (mis) begin
          e_fpc = mq[0].alt;
          mq.delete(); m_head = 0;
        end else begin
          if (rob.rs_ready) begin
            off = slot(rob.rs_rob_id);
            if (off < mq.size()) begin mq[off].rdy = 1'b1; mq[off].val = rob.rs_value; end
          end
          if (rob.lsb_ready) begin
            off = slot(rob.lsb_rob_id);
            if (off < mq.size()) begin mq[off].rdy = 1'b1; mq[off].val = rob.lsb_value; end
          end
          if (do_commit) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % 8;
          end
          if (rob.alloc_valid && !was_full) begin
            ne.kind = rob.alloc_kind; ne.rd = rob.alloc_rd; ne.pred = rob.alloc_pred_taken;
            ne.alt = rob.alloc_alt_pc; ne.rdy = 1'b0; ne.val = 32'h0;
            mq.push_back(ne);
          end
        end
      end
    end
  end

  task automatic chk_query(input string name, input logic [2:0] qid,
                           input logic act_rdy, input logic [31:0] act_val);
    int off;
    logic stored, lhit, rhit, xr;
    logic [31:0] xv;
    off = slot(qid);
    if (off < mq.size()) begin
      stored = mq[off].rdy;
      lhit = rob.lsb_ready && (rob.lsb_rob_id == qid);
      rhit = rob.rs_ready && (rob.rs_rob_id == qid);
      xr = stored | lhit | rhit;
      xv = stored ? mq[off].val : (lhit ? rob.lsb_value : rob.rs_value);
      chk({name, "_ready"}, act_rdy, xr);
      if (xr) chk({name, "_value"}, act_val, xv);
    end
  endtask

  // ---------------- per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk_in);
      chk("alloc_id", rob.alloc_id, (m_head + mq.size()) % 8);
      chk("full", rob.full, mq.size() == 8);
      chk("commit_valid", rob.commit_valid, e_cv && rdy_in);
      chk("flush", rob.flush, e_flush && rdy_in);
      if (e_cv && rdy_in) begin
        chk("commit_kind", rob.commit_kind, e_kind);
        chk("commit_rob_id", rob.commit_rob_id, e_id);
        chk("commit_rd", rob.commit_rd, e_rd);
        chk("commit_value", rob.commit_value, e_val);
      end
      if (e_flush && rdy_in) chk("flush_pc", rob.flush_pc, e_fpc);
      chk_query("query1", rob.query_id1, rob.query_ready1, rob.query_value1);
      chk_query("query2", rob.query_id2, rob.query_ready2, rob.query_value2);
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic idle();
    rob.alloc_valid = 1'b0; rob.alloc_kind = 2'd0; rob.alloc_rd = 5'd0;
    rob.alloc_pred_taken = 1'b0; rob.alloc_alt_pc = 32'h0;
    rob.rs_ready = 1'b0; rob.rs_rob_id = 3'd0; rob.rs_value = 32'h0;
    rob.lsb_ready = 1'b0; rob.lsb_rob_id = 3'd0; rob.lsb_value = 32'h0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
  endtask

  task automatic alloc(input logic [1:0] kind, input logic [4:0] rd,
                       input logic pred, input logic [31:0] alt);
    rob.alloc_valid = 1'b1; rob.alloc_kind = kind; rob.alloc_rd = rd;
    rob.alloc_pred_taken = pred; rob.alloc_alt_pc = alt;
    tick();
    rob.alloc_valid = 1'b0;
  endtask

  task automatic wb_rs(input logic [2:0] id, input logic [31:0] val);
    rob.rs_ready = 1'b1; rob.rs_rob_id = id; rob.rs_value = val;
    tick();
    rob.rs_ready = 1'b0;
  endtask

  task automatic wb_lsb(input logic [2:0] id, input logic [31:0] val);
    rob.lsb_ready = 1'b1; rob.lsb_rob_id = id; rob.lsb_value = val;
    tick();
    rob.lsb_ready = 1'b0;
  endtask

  // ---------------- directed scenarios, then a randomised soak
  initial begin
    idle();
    rob.query_id1 = 3'd0; rob.query_id2 = 3'd0;
    rst_in = 1'b0; rdy_in = 1'b1;
    tick(); tick();
    chk("lit_rst_commit_valid", rob.commit_valid, 32'd0);
    chk("lit_rst_flush", rob.flush, 32'd0);
    chk("lit_rst_full", rob.full, 32'd0);
    chk("lit_rst_alloc_id", rob.alloc_id, 32'd0);
    chk("lit_rst_flush_pc", rob.flush_pc, 32'd0);
    chk("lit_rst_commit_value", rob.commit_value, 32'd0);
    rst_in = 1'b1;

    // basic allocate / write / retire
    alloc(2'd0, 5'd5, 1'b0, 32'h0);
    wb_rs(3'd0, 32'h1234);
    chk("lit_no_early_commit", rob.commit_valid, 32'd0);
    tick();
    chk("lit_basic_cv", rob.commit_valid, 32'd1);
    chk("lit_basic_rd", rob.commit_rd, 32'd5);
    chk("lit_basic_value", rob.commit_value, 32'h1234);
    chk("lit_basic_id", rob.commit_rob_id, 32'd0);
    tick();
    chk("lit_basic_pulse", rob.commit_valid, 32'd0);

    // fill, overflow, wrap-around, commit+alloc while full
    do_reset();
    for (int i = 0; i < 8; i++) alloc(2'd3, 5'd0, 1'b0, 32'h0);
    chk("lit_full", rob.full, 32'd1);
    chk("lit_full_id", rob.alloc_id, 32'd0);
    alloc(2'd3, 5'd0, 1'b0, 32'h0);
    chk("lit_9th_id", rob.alloc_id, 32'd0);
    chk("lit_9th_full", rob.full, 32'd1);
    wb_rs(3'd0, 32'hA0);
    tick();
    chk("lit_drain_cv", rob.commit_valid, 32'd1);
    chk("lit_drain_full", rob.full, 32'd0);
    chk("lit_drain_id", rob.alloc_id, 32'd0);
    alloc(2'd0, 5'd6, 1'b0, 32'h0);
    chk("lit_wrap_id", rob.alloc_id, 32'd1);
    chk("lit_wrap_full", rob.full, 32'd1);
    wb_rs(3'd1, 32'hB1);
    rob.alloc_valid = 1'b1;
    tick();
    rob.alloc_valid = 1'b0;
    chk("lit_fullcommit_cv", rob.commit_valid, 32'd1);
    chk("lit_fullcommit_rid", rob.commit_rob_id, 32'd1);
    chk("lit_fullcommit_refused", rob.alloc_id, 32'd1);
    chk("lit_fullcommit_full", rob.full, 32'd0);

    // out-of-order completion retires in order
    do_reset();
    alloc(2'd0, 5'd1, 1'b0, 32'h0);
    alloc(2'd0, 5'd2, 1'b0, 32'h0);
    alloc(2'd0, 5'd3, 1'b0, 32'h0);
    wb_rs(3'd2, 32'h22);
    wb_lsb(3'd1, 32'h11);
    wb_rs(3'd0, 32'h10);
    tick();
    chk("lit_ooo0_id", rob.commit_rob_id, 32'd0);
    chk("lit_ooo0_val", rob.commit_value, 32'h10);
    tick();
    chk("lit_ooo1_id", rob.commit_rob_id, 32'd1);
    chk("lit_ooo1_val", rob.commit_value, 32'h11);
    tick();
    chk("lit_ooo2_id", rob.commit_rob_id, 32'd2);
    chk("lit_ooo2_cv", rob.commit_valid, 32'd1);
    tick();
    chk("lit_ooo_done", rob.commit_valid, 32'd0);

    // operand query bypass and priority
    do_reset();
    for (int i = 0; i < 4; i++) alloc(2'd0, 5'(i), 1'b0, 32'h0);
    rob.query_id1 = 3'd3; rob.query_id2 = 3'd0;
    rob.rs_ready = 1'b1; rob.rs_rob_id = 3'd3; rob.rs_value = 32'hAB;
    #1;
    chk("lit_bypass_ready", rob.query_ready1, 32'd1);
    chk("lit_bypass_value", rob.query_value1, 32'hAB);
    chk("lit_notready", rob.query_ready2, 32'd0);
    tick();
    rob.rs_rob_id = 3'd2; rob.rs_value = 32'h66;
    rob.lsb_ready = 1'b1; rob.lsb_rob_id = 3'd2; rob.lsb_value = 32'h55;
    rob.query_id2 = 3'd2;
    #1;
    chk("lit_bypass_lsb_first", rob.query_value2, 32'h55);
    tick();
    idle();
    #1;
    chk("lit_same_id_lsb_wins", rob.query_value2, 32'h55);
    chk("lit_stored_value", rob.query_value1, 32'hAB);
    rob.lsb_ready = 1'b1; rob.lsb_rob_id = 3'd3; rob.lsb_value = 32'hEE;
    #1;
    chk("lit_stored_over_bus", rob.query_value1, 32'hAB);
    idle();

    // branch mispredict and correct prediction
    do_reset();
    alloc(2'd2, 5'd0, 1'b0, 32'h100);
    alloc(2'd0, 5'd7, 1'b0, 32'h0);
    alloc(2'd0, 5'd8, 1'b0, 32'h0);
    rob.rs_ready = 1'b1; rob.rs_rob_id = 3'd1; rob.rs_value = 32'h77;
    rob.lsb_ready = 1'b1; rob.lsb_rob_id = 3'd2; rob.lsb_value = 32'h88;
    tick();
    idle();
    wb_rs(3'd0, 32'h1);
    rob.alloc_valid = 1'b1;
    tick();
    rob.alloc_valid = 1'b0;
    chk("lit_mis_cv", rob.commit_valid, 32'd1);
    chk("lit_mis_kind", rob.commit_kind, 32'd2);
    chk("lit_mis_flush", rob.flush, 32'd1);
    chk("lit_mis_pc", rob.flush_pc, 32'h100);
    tick();
    chk("lit_post_flush_cv", rob.commit_valid, 32'd0);
    chk("lit_post_flush_id", rob.alloc_id, 32'd0);
    chk("lit_post_flush_pulse", rob.flush, 32'd0);
    tick();
    chk("lit_younger_dropped", rob.commit_valid, 32'd0);
    alloc(2'd2, 5'd0, 1'b1, 32'h200);
    wb_rs(3'd0, 32'h3);
    tick();
    chk("lit_good_branch_cv", rob.commit_valid, 32'd1);
    chk("lit_good_branch_noflush", rob.flush, 32'd0);

    // rdy_in stall
    do_reset();
    alloc(2'd0, 5'd9, 1'b0, 32'h0);
    wb_rs(3'd0, 32'h77);
    rdy_in = 1'b0;
    rob.alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_stall_cv", rob.commit_valid, 32'd0);
    end
    chk("lit_stall_alloc_id", rob.alloc_id, 32'd1);
    rob.alloc_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    chk("lit_resume_cv", rob.commit_valid, 32'd1);
    chk("lit_resume_val", rob.commit_value, 32'h77);

    // asynchronous reset mid-run
    alloc(2'd0, 5'd4, 1'b0, 32'h0);
    wb_rs(3'd1, 32'h44);
    tick();
    chk("lit_pre_rst_cv", rob.commit_valid, 32'd1);
    #1 rst_in = 1'b0;
    #1;
    chk("lit_async_rst_cv", rob.commit_valid, 32'd0);
    chk("lit_async_rst_id", rob.alloc_id, 32'd0);
    chk("lit_async_rst_val", rob.commit_value, 32'd0);
    tick();
    rst_in = 1'b1;

    // randomised soak against the model
    for (int c = 0; c < 400; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      rob.alloc_valid = $urandom_range(0, 1);
      rob.alloc_kind = 2'($urandom_range(0, 3));
      rob.alloc_rd = 5'($urandom_range(0, 31));
      rob.alloc_pred_taken = 1'($urandom_range(0, 1));
      rob.alloc_alt_pc = $urandom;
      rob.rs_ready = $urandom_range(0, 1);
      rob.rs_rob_id = 3'($urandom_range(0, 7));
      rob.rs_value = $urandom;
      rob.lsb_ready = ($urandom_range(0, 2) == 0);
      rob.lsb_rob_id = 3'($urandom_range(0, 7));
      rob.lsb_value = $urandom;
      rob.query_id1 = 3'($urandom_range(0, 7));
      rob.query_id2 = 3'($urandom_range(0, 7));
      tick();
    end
    idle();
    rdy_in = 1'b1;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
